// File: rtl/tt_arith_pkg.sv
// Shared arithmetic package: divider FSM states and default operand widths.
package tt_arith_pkg;

  localparam int unsigned DW_DEF = 12;
  localparam int unsigned VW_DEF = 6;
  localparam int unsigned CW_DEF = $clog2(DW_DEF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/restoring_divider_if.sv
// Operand/result handshake bundle for the restoring divider.
interface restoring_divider_if #(
  parameter int unsigned DW = tt_arith_pkg::DW_DEF,
  parameter int unsigned VW = tt_arith_pkg::VW_DEF
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned VW = tt_arith_pkg::VW_DEF
) (
  input  logic [VW:0]   r,
  input  logic          q_msb,
  input  logic [VW-1:0] d,
  output logic [VW:0]   r_next,
  output logic          q_bit
);

  logic [VW+1:0] shifted;
  logic [VW+1:0] trial;

  // Negative trial result (sign bit set) means restore the shifted remainder.
  always_comb begin
    shifted = {r, q_msb};
    trial   = shifted - (VW+2)'(d);
    q_bit   = ~trial[VW+1];
    r_next  = trial[VW+1] ? shifted[VW:0] : trial[VW:0];
  end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
module restoring_divider
  import tt_arith_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned VW = VW_DEF
) (
  input logic               clk,
  input logic               rst_n,
  restoring_divider_if.slave bus
);

  localparam int unsigned CW = $clog2(DW);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW:0]   r_q, r_d;
  logic [VW-1:0] d_q, d_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dz_q, dz_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic [VW:0]   r_next;
  logic          q_bit;

  div_step #(.VW(VW)) u_step (
    .r      (r_q),
    .q_msb  (q_q[DW-1]),
    .d      (d_q),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    r_d         = r_q;
    d_d         = d_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dz_d        = dz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          q_d = bus.dividend;
          d_d = bus.divisor;
          r_d = '0;
          if (bus.divisor != '0) begin
            cnt_d   = CW'(DW - 1);
            state_d = S_RUN;
          end else begin
            quo_d   = '1;
            rem_d   = bus.dividend[VW-1:0];
            dz_d    = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        q_d   = {q_q[DW-2:0], q_bit};
        r_d   = r_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          quo_d   = {q_q[DW-2:0], q_bit};
          rem_d   = r_next[VW-1:0];
          dz_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      d_q         <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      r_q         <= r_d;
      d_q         <= d_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dz_q        <= dz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and random bench for restoring_divider with a result scoreboard.
module tb_restoring_divider;

  localparam int unsigned DW = 12;
  localparam int unsigned VW = 6;

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
    int            lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  restoring_divider_if #(.DW(DW), .VW(VW)) bus ();

  restoring_divider #(.DW(DW), .VW(VW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    logic [DW-1:0] av;
    av = DW'(a);
    if (b == 0) begin
      e.q = '1;
      e.r = av[VW-1:0];
      e.dz = 1'b1;
      e.lat = 1;
    end else begin
      e.q = DW'(a / b);
      e.r = VW'(a % b);
      e.dz = 1'b0;
      e.lat = DW;
    end
    return e;
  endfunction

  // Present operands for one edge and push the expected result.
  task automatic start_op(input int a, input int b);
    @(negedge clk);
    check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = DW'(a);
    bus.divisor  = VW'(b);
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait for the result, optionally stall the consumer, then handshake.
  task automatic finish_op(input int hold);
    int   lat;
    bit   done;
    exp_t e;
    logic [DW-1:0] q0;
    logic [VW-1:0] r0;
    lat = 0;
    done = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.out_valid) done = 1'b1;
    end
    check("result_timeout", 32'(done), 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check("latency", 32'(lat), 32'(e.lat));
    check("quotient", 32'(bus.quotient), 32'(e.q));
    check("remainder", 32'(bus.remainder), 32'(e.r));
    check("div_zero", 32'(bus.div_zero), 32'(e.dz));
    q0 = bus.quotient;
    r0 = bus.remainder;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.dividend = DW'(i + 17);
      bus.divisor  = VW'(i + 3);
      @(posedge clk);
      #1;
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_quotient", 32'(bus.quotient), 32'(q0));
      check("hold_remainder", 32'(bus.remainder), 32'(r0));
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input int a, input int b, input int hold);
    start_op(a, b);
    finish_op(hold);
  endtask

  initial begin
    exp_t dropped;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_div_zero", 32'(bus.div_zero), 32'd0);

    // Reset in the middle of a division discards it.
    start_op(3969, 63);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrun_rst_quotient", 32'(bus.quotient), 32'd0);
    check("midrun_rst_remainder", 32'(bus.remainder), 32'd0);
    dropped = sb.pop_front();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrun_release_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrun_release_out_valid", 32'(bus.out_valid), 32'd0);

    // Directed cases.
    run_op(3969, 63, 0);
    run_op(1000, 7, 0);
    run_op(4095, 1, 0);
    run_op(5, 0, 0);
    run_op(1000, 7, 20);
    run_op(0, 5, 0);
    run_op(62, 63, 0);

    // Round trip of every 6x6 product.
    for (int a = 1; a < 64; a++) begin
      for (int b = 1; b < 64; b++) begin
        run_op(a * b, b, 0);
      end
    end

    // Random pairs, divisor zero included.
    for (int k = 0; k < 1000; k++) begin
      run_op(int'($urandom_range(0, 4095)), int'($urandom_range(0, 63)), 0);
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
